// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the single-cycle 16-bit MIPS instruction-memory
// write path: default geometry of the instruction memory and the state
// encoding of the program loader.
package mips_pkg;

  localparam int MIPS_DEPTH      = 16;
  localparam int MIPS_WIDTH      = 16;
  localparam int MIPS_BPW        = MIPS_WIDTH / 8;
  localparam int MIPS_ADDR_WIDTH = $clog2(MIPS_DEPTH * MIPS_BPW);
  localparam int MIPS_CNT_WIDTH  = $clog2(MIPS_DEPTH) + 1;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_CHK  = 2'd2,
    LD_FIN  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
// Byte-stream input handshake plus instruction-memory write port of the
// program loader.
//   in_valid/in_ready/in_byte : host -> loader byte stream
//   mem_we/mem_addr/mem_wdata : loader -> instruction memory write port
// Modports:
//   master : host/bench side (drives the stream, observes the write port)
//   slave  : loader side
interface imem_loader_if #(
  parameter int WIDTH      = mips_pkg::MIPS_WIDTH,
  parameter int ADDR_WIDTH = mips_pkg::MIPS_ADDR_WIDTH
);

  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            in_byte;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;

  modport master (
    output in_valid, in_byte,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_byte,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// byte_packer
// Shifts BPW bytes into a WIDTH-bit word, first byte ending up in the MSB.
// word_valid is a combinational strobe in the cycle the last byte of a word
// is presented with byte_valid; word then holds the complete word.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clr         : synchronous clear of any partially collected word
//   byte_valid  : byte_in is accepted this cycle
//   byte_in     : stream byte
//   word_valid  : the accepted byte completes a word
//   word        : collected bytes including the current byte_in
module byte_packer import mips_pkg::*; #(
  parameter int WIDTH = MIPS_WIDTH,
  parameter int BPW   = MIPS_BPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             byte_valid,
  input  logic [7:0]       byte_in,
  output logic             word_valid,
  output logic [WIDTH-1:0] word
);

  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Earlier bytes sit in the low bits of acc_q; shifting by one byte per
  // accepted byte leaves byte 0 in the MSB once the word is complete.
  always_comb begin
    word       = (acc_q << 8) | WIDTH'(byte_in);
    word_valid = byte_valid && (idx_q == LAST_IDX);
    acc_d      = acc_q;
    idx_d      = idx_q;
    if (clr) begin
      acc_d = '0;
      idx_d = '0;
    end else if (byte_valid) begin
      if (word_valid) begin
        acc_d = '0;
        idx_d = '0;
      end else begin
        acc_d = word;
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      idx_q <= '0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Program loader for the instruction memory. Packs a valid/ready byte
// stream into instruction words (MSB first) and writes them to consecutive
// word-aligned byte addresses starting at 0.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a load (sampled only when idle)
//   num_words  : words to load, clamped to DEPTH, latched on start
//   bus        : imem_loader_if.slave (byte stream in, memory write port out)
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse at end of load
//   err        : checksum mismatch, sticky until next start
// Build option: define LOADER_CHECKSUM_EN to expect a trailing BPW-byte
// checksum word (sum of all written words mod 2^WIDTH) and drive err.
// Without it there is no CHK state and err is tied low.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting data bytes, writing each completed word
// CHK   | accepting the checksum word (LOADER_CHECKSUM_EN only)
// FIN   | done pulse, back to IDLE
module imem_loader import mips_pkg::*; #(
  parameter int DEPTH      = MIPS_DEPTH,
  parameter int WIDTH      = MIPS_WIDTH,
  parameter int BPW        = MIPS_BPW,
  parameter int ADDR_WIDTH = $clog2(DEPTH * BPW),
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_words,
  imem_loader_if.slave         bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [1:0] S_IDLE = LD_IDLE;
  localparam logic [1:0] S_LOAD = LD_LOAD;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [1:0] S_CHK  = LD_CHK;
`endif
  localparam logic [1:0] S_FIN  = LD_FIN;

  logic [1:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [WIDTH-1:0]      sum_q, sum_d;
  logic                  err_q, err_d;
`endif

  logic                 ready;
  logic                 accept;
  logic                 pk_clr;
  logic                 pk_word_valid;
  logic [WIDTH-1:0]     pk_word;
  logic [CNT_WIDTH-1:0] clamp;

  assign clamp = (num_words > CNT_WIDTH'(DEPTH)) ? CNT_WIDTH'(DEPTH) : num_words;

  // cnt_q counts words still to be received, so it reaches 0 as soon as the
  // last data word is packed; ready then drops for the final write cycle
  // rather than swallowing bytes that belong to no word.
  always_comb begin
    ready = (state_q == S_LOAD) && (cnt_q != '0);
`ifdef LOADER_CHECKSUM_EN
    if (state_q == S_CHK) ready = 1'b1;
`endif
  end

  assign accept = bus.in_valid && ready;
  assign pk_clr = (state_q == S_IDLE);

  byte_packer #(
    .WIDTH (WIDTH),
    .BPW   (BPW)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pk_clr),
    .byte_valid (accept),
    .byte_in    (bus.in_byte),
    .word_valid (pk_word_valid),
    .word       (pk_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    // The address moves on at the end of each write cycle.
    if (we_q) addr_d = addr_q + ADDR_WIDTH'(BPW);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d  = clamp;
          addr_d = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d  = '0;
          err_d  = 1'b0;
`endif
          state_d = (clamp == '0) ? S_FIN : S_LOAD;
        end
      end
      S_LOAD: begin
        if (pk_word_valid) begin
          we_d    = 1'b1;
          wdata_d = pk_word;
          cnt_d   = cnt_q - CNT_WIDTH'(1);
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_q + pk_word;
          // The final write overlaps the first checksum byte cycle; the
          // write port is independent of the stream so nothing stalls.
          if (cnt_q == CNT_WIDTH'(1)) state_d = S_CHK;
`endif
        end else if (cnt_q == '0) begin
          // Reached in the final write cycle, so done follows the write.
          state_d = S_FIN;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (pk_word_valid) begin
          err_d   = (pk_word != sum_q);
          state_d = S_FIN;
        end
      end
`endif
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.in_ready  = ready;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_FIN);
`ifdef LOADER_CHECKSUM_EN
  assign err           = err_q;
`else
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Self-checking bench for imem_loader: a transaction-level model predicts
// every output each cycle from the stream rules; directed loads pin the
// model against hand-computed writes, then randomized loads follow.
module tb_imem_loader;
  import mips_pkg::*;

  localparam int DEPTH = 16;
  localparam int BPW   = 2;
  localparam int AW    = 5;
  localparam int CW    = 5;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct { int addr; int data; } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_words = '0;
  logic          busy, done, err;

  imem_loader_if #(.WIDTH(16), .ADDR_WIDTH(AW)) bus ();

  imem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_words (num_words),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  bit armed = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_active = 0, m_half = 0, done_cd = 0;
  int          m_n = 0, m_got = 0, m_words = 0;
  logic [7:0]  m_hi = '0;
  logic [15:0] m_sum = '0;
  logic        exp_ready = 0, exp_busy = 0, exp_done = 0, exp_we = 0, exp_err = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [15:0] exp_data = '0;
  wr_t         m_log[$];

  always @(posedge clk) begin
    bit acc;
    bit nd;
    logic [15:0] w;
    cyc++;
    armed = 1'b1;
    acc = exp_ready && (bus.in_valid === 1'b1);
    nd = 1'b0;
    if (rst) begin
      m_active = 0; m_half = 0; done_cd = 0;
      exp_ready = 0; exp_busy = 0; exp_done = 0; exp_we = 0; exp_err = 0;
      exp_addr = '0; exp_data = '0;
    end else begin
      exp_we = 0;
      if (done_cd) begin done_cd = 0; nd = 1; end
      if (exp_done) m_active = 0;
      if (!exp_busy && start) begin
        m_n = (num_words > DEPTH) ? DEPTH : int'(num_words);
        m_got = 0; m_words = 0; m_sum = '0; m_half = 0; exp_err = 0; m_active = 1;
        if (m_n == 0) nd = 1;
      end else if (acc) begin
        m_got++;
        if (!m_half) begin
          m_hi = bus.in_byte; m_half = 1;
        end else begin
          m_half = 0;
          w = {m_hi, bus.in_byte};
          if (m_words < m_n) begin
            exp_we = 1; exp_addr = AW'(m_words * BPW); exp_data = w;
            m_log.push_back('{m_words * BPW, int'(w)});
            m_sum += w;
            m_words++;
            if (m_words == m_n && !CHK_EN) done_cd = 1;
          end else begin
            exp_err = (w != m_sum);
            nd = 1;
          end
        end
      end
      exp_done = nd;
      exp_busy = m_active;
      exp_ready = m_active && !nd && (m_got < 2 * m_n + (CHK_EN ? 2 : 0));
    end
  end

  // ---------------- per-cycle compare ----------------
  int dut_we_cnt = 0, last_we_cyc = 0, done_cyc = 0;

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
      chk("err", 32'(err), 32'(exp_err));
      if (exp_we) begin
        chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(exp_data));
      end
      if (bus.mem_we === 1'b1) begin dut_we_cnt++; last_we_cyc = cyc; end
      if (done === 1'b1) done_cyc = cyc;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] dq[$];
  int stall = 0;
  int s_cyc = 0;

  task automatic push_word(input logic [15:0] w);
    dq.push_back(w[15:8]);
    dq.push_back(w[7:0]);
  endtask

  task automatic wait_done();
    int k = 0;
    while (done !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    if (k == 300) chk("done_timeout", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  // Caller is at a negedge with the loader idle. dq holds the data bytes.
  task automatic run_load(input int n, input int gap, input bit bad_sum, input int rst_at);
    logic [7:0] s[$];
    logic [15:0] sum;
    int nc;
    nc = (n > DEPTH) ? DEPTH : n;
    s = dq;
    if (CHK_EN && nc > 0) begin
      sum = '0;
      for (int i = 0; i < nc; i++) sum += {s[2*i], s[2*i+1]};
      if (bad_sum) sum += 16'd1;
      s.push_back(sum[15:8]);
      s.push_back(sum[7:0]);
    end
    stall = 0;
    start = 1'b1; num_words = CW'(n); s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < s.size(); i++) begin
      int k;
      if (i == rst_at) begin
        bus.in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.in_valid = 1'b1; bus.in_byte = s[i];
      if (gap == 2 && i == 1 && $urandom_range(0, 3) == 0) begin
        start = 1'b1; num_words = CW'($urandom_range(0, 20));
      end
      k = 0;
      while (bus.in_ready !== 1'b1 && k < 40) begin stall++; @(negedge clk); k++; end
      if (k == 40) chk("ready_timeout", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      start = 1'b0;
    end
    bus.in_valid = 1'b0;
    wait_done();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_byte  = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    @(negedge clk);

    // Two words, back-to-back
    m_log.delete(); dut_we_cnt = 0; dq.delete();
    push_word(16'h1234); push_word(16'h5678);
    run_load(2, 0, 0, -1);
    chk("A_nwr", m_log.size(), 2);
    chk("A_addr0", m_log[0].addr, 32'h00);
    chk("A_data0", m_log[0].data, 32'h1234);
    chk("A_addr1", m_log[1].addr, 32'h02);
    chk("A_data1", m_log[1].data, 32'h5678);
    chk("A_dut_nwr", dut_we_cnt, 2);
    chk("A_stall", stall, 0);
`ifndef LOADER_CHECKSUM_EN
    chk("A_done_lat", done_cyc - last_we_cyc, 1);
`endif

    // Same load, in_valid low every other cycle
    m_log.delete(); dut_we_cnt = 0;
    run_load(2, 1, 0, -1);
    chk("B_nwr", m_log.size(), 2);
    chk("B_data0", m_log[0].data, 32'h1234);
    chk("B_data1", m_log[1].data, 32'h5678);
    chk("B_dut_nwr", dut_we_cnt, 2);

    // Clamp: 20 requested, 16 written
    m_log.delete(); dut_we_cnt = 0; dq.delete();
    for (int i = 0; i < 16; i++) push_word(16'($urandom));
    run_load(20, 0, 0, -1);
    chk("C_nwr", m_log.size(), 16);
    chk("C_last_addr", m_log[15].addr, 32'h1E);
    chk("C_dut_nwr", dut_we_cnt, 16);

    // Zero words
    m_log.delete(); dut_we_cnt = 0; dq.delete();
    run_load(0, 0, 0, -1);
    chk("D_dut_nwr", dut_we_cnt, 0);
    chk("D_done_lat", done_cyc - s_cyc, 1);

    // Reset after three bytes, then a fresh one-word load
    dq.delete(); push_word(16'h1234); push_word(16'h5678);
    run_load(2, 0, 0, 3);
    dut_we_cnt = 0;
    repeat (4) @(negedge clk);
    chk("E_no_we", dut_we_cnt, 0);
    m_log.delete(); dq.delete(); push_word(16'hABCD);
    run_load(1, 0, 0, -1);
    chk("E_nwr", dut_we_cnt, 1);
    chk("E_addr", m_log[0].addr, 32'h00);
    chk("E_data", m_log[0].data, 32'hABCD);

`ifdef LOADER_CHECKSUM_EN
    dq.delete(); push_word(16'h1234); push_word(16'h5678);
    run_load(2, 0, 0, -1);
    chk("F_err_good", 32'(err), 0);
    run_load(2, 0, 1, -1);
    chk("F_err_bad", 32'(err), 1);
    repeat (3) @(negedge clk);
    chk("F_err_held", 32'(err), 1);
    dq.delete(); push_word(16'h00FF);
    run_load(1, 0, 0, -1);
    chk("F_err_cleared", 32'(err), 0);
`endif

    // Randomized loads, gaps, spurious starts, resets and idle bytes
    for (int t = 0; t < 30; t++) begin
      int n, nb, rat;
      n = $urandom_range(0, 20);
      nb = 2 * ((n > DEPTH) ? DEPTH : n);
      dq.delete();
      for (int i = 0; i < nb; i++) dq.push_back(8'($urandom));
      rat = (nb > 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      run_load(n, $urandom_range(0, 2), 1'($urandom_range(0, 1)), rat);
      bus.in_valid = 1'b1; bus.in_byte = 8'($urandom);
      repeat (2) @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
